// File: rtl/sys_defs.sv
// Shared definitions for the R10K front end.
// Dispatch packet, queue entry layout and RV32 opcodes.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic              valid;
    logic [31:0]       inst;
    logic [`XLEN-1:0]  PC;
    logic [`XLEN-1:0]  NPC;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic [4:0]        dest;
  } DISPATCH_PACKET_R10K;

  typedef struct packed {
    logic [31:0]       inst;
    logic [`XLEN-1:0]  PC;
    logic [`XLEN-1:0]  NPC;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic [4:0]        dest;
    logic              branch;
  } dq_entry_t;

endpackage

// File: rtl/inst_field_decode.sv
// Register-field decode for one enqueue lane.
// Purely combinational; unused fields read as zero.
module inst_field_decode
  import sys_defs::*;
(
  input  logic [31:0] inst,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic [4:0]  dest,
  output logic        branch
);

  logic [6:0] opcode;
  logic       unused_funct;

  assign opcode       = inst[6:0];
  assign unused_funct = ^{inst[31:25], inst[14:12]};

  // Select which register fields the opcode actually uses
  always_comb begin
    src1   = '0;
    src2   = '0;
    dest   = '0;
    branch = 1'b0;
    unique case (1'b1)
      (opcode == OP_REG): begin
        src1 = inst[19:15];
        src2 = inst[24:20];
        dest = inst[11:7];
      end
      (opcode == OP_IMM),
      (opcode == OP_LOAD): begin
        src1 = inst[19:15];
        dest = inst[11:7];
      end
      (opcode == OP_STORE): begin
        src1 = inst[19:15];
        src2 = inst[24:20];
      end
      (opcode == OP_BRANCH): begin
        src1   = inst[19:15];
        src2   = inst[24:20];
        branch = 1'b1;
      end
      (opcode == OP_JAL): begin
        dest   = inst[11:7];
        branch = 1'b1;
      end
      (opcode == OP_JALR): begin
        src1   = inst[19:15];
        dest   = inst[11:7];
        branch = 1'b1;
      end
      (opcode == OP_LUI),
      (opcode == OP_AUIPC): begin
        dest = inst[11:7];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order fetch-to-dispatch instruction buffer.
// Enqueues whole fetch groups, retires the dispatched prefix.
module dispatch_queue
  import sys_defs::*;
#(
  parameter int N_WAY = `N_WAY,
  parameter int DEPTH = 8,
  parameter int XLEN  = `XLEN
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_WAY-1:0]                 fetch_valid,
  input  logic [N_WAY-1:0][31:0]           fetch_inst,
  input  logic [N_WAY-1:0][XLEN-1:0]       fetch_PC,
  input  logic [N_WAY-1:0][XLEN-1:0]       fetch_NPC,
  output logic                             fetch_ready,
  input  logic [N_WAY-1:0]                 dispatched,
  input  logic                             take_branch,
  output DISPATCH_PACKET_R10K [N_WAY-1:0]  dispatch_packet,
  output logic [N_WAY-1:0]                 branch_inst,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  dq_entry_t         mem_q [DEPTH];
  dq_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [N_WAY-1:0][4:0] dec_src1;
  logic [N_WAY-1:0][4:0] dec_src2;
  logic [N_WAY-1:0][4:0] dec_dest;
  logic [N_WAY-1:0]      dec_br;

  logic [N_WAY-1:0]  lane_valid;
  logic              enq_en;
  logic [CW-1:0]     enq_num;
  logic [CW-1:0]     deq_num;
  logic              run;
  logic [PW-1:0]     rd_idx;

  for (genvar g = 0; g < N_WAY; g++) begin : g_dec
    inst_field_decode u_dec (
      .inst   (fetch_inst[g]),
      .src1   (dec_src1[g]),
      .src2   (dec_src2[g]),
      .dest   (dec_dest[g]),
      .branch (dec_br[g])
    );
  end

  assign fetch_ready = (count_q <= CW'(DEPTH - N_WAY));
  assign count       = count_q;
  assign enq_en      = fetch_ready && !take_branch;

  // Present the oldest entries; invalid lanes drive zeros
  always_comb begin
    lane_valid      = '0;
    dispatch_packet = '0;
    branch_inst     = '0;
    rd_idx          = '0;
    for (int i = 0; i < N_WAY; i++) begin
      rd_idx        = head_q + PW'(i);
      lane_valid[i] = (CW'(i) < count_q) && !take_branch;
      if (lane_valid[i]) begin
        dispatch_packet[i].valid = 1'b1;
        dispatch_packet[i].inst  = mem_q[rd_idx].inst;
        dispatch_packet[i].PC    = mem_q[rd_idx].PC;
        dispatch_packet[i].NPC   = mem_q[rd_idx].NPC;
        dispatch_packet[i].src1  = mem_q[rd_idx].src1;
        dispatch_packet[i].src2  = mem_q[rd_idx].src2;
        dispatch_packet[i].dest  = mem_q[rd_idx].dest;
        branch_inst[i]           = mem_q[rd_idx].branch;
      end
    end
  end

  // Count enqueued lanes and the leading run of dispatched lanes
  always_comb begin
    enq_num = '0;
    deq_num = '0;
    run     = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if (enq_en && fetch_valid[i]) enq_num = enq_num + CW'(1);
      if (run && dispatched[i] && lane_valid[i]) begin
        deq_num = deq_num + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next-state: flush wins, else write tail group and retire prefix
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (take_branch) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < N_WAY; i++) begin
        if (enq_en && fetch_valid[i]) begin
          mem_d[tail_q + PW'(i)] = '{
            inst:   fetch_inst[i],
            PC:     fetch_PC[i],
            NPC:    fetch_NPC[i],
            src1:   dec_src1[i],
            src2:   dec_src2[i],
            dest:   dec_dest[i],
            branch: dec_br[i]
          };
        end
      end
      head_d  = head_q + PW'(deq_num);
      tail_d  = tail_q + PW'(enq_num);
      count_d = count_q + enq_num - deq_num;
    end
  end

  // Queue state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue.
// Hand-computed expectations checked with immediate assertions.
module tb_dispatch_queue;
  import sys_defs::*;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            fetch_valid;
  logic [1:0][31:0]      fetch_inst;
  logic [1:0][31:0]      fetch_PC;
  logic [1:0][31:0]      fetch_NPC;
  logic                  fetch_ready;
  logic [1:0]            dispatched;
  logic                  take_branch;
  DISPATCH_PACKET_R10K [1:0] dispatch_packet;
  logic [1:0]            branch_inst;
  logic [3:0]            count;

  int tests;
  int failed;
  logic [31:0] exp_pc;
  logic [31:0] nxt_pc;

  dispatch_queue #(.N_WAY(2), .DEPTH(8), .XLEN(32)) dut (
    .clock           (clk),
    .reset           (rst_n),
    .fetch_valid     (fetch_valid),
    .fetch_inst      (fetch_inst),
    .fetch_PC        (fetch_PC),
    .fetch_NPC       (fetch_NPC),
    .fetch_ready     (fetch_ready),
    .dispatched      (dispatched),
    .take_branch     (take_branch),
    .dispatch_packet (dispatch_packet),
    .branch_inst     (branch_inst),
    .count           (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] add_i(int rd, int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] beq_i(int rs1, int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'b0, 7'b1100011};
  endfunction

  function automatic logic [31:0] lw_i(int rd, int rs1);
    return {12'h004, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] sw_i(int rs2, int rs1);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b010, 5'b00100, 7'b0100011};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc);
    fetch_valid   = v;
    fetch_inst[0] = i0;
    fetch_inst[1] = i1;
    fetch_PC[0]   = pc;
    fetch_PC[1]   = pc + 32'd4;
    fetch_NPC[0]  = pc + 32'd4;
    fetch_NPC[1]  = pc + 32'd8;
  endtask

  task automatic idle();
    fetch_valid = '0;
    dispatched  = '0;
    take_branch = 1'b0;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    clk = 0;
    rst_n = 0;
    fetch_valid = '0;
    fetch_inst = '0;
    fetch_PC = '0;
    fetch_NPC = '0;
    dispatched = '0;
    take_branch = 0;

    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    chk("rst_valid", 64'({dispatch_packet[1].valid,
                          dispatch_packet[0].valid}), 64'd0);
    chk("rst_branch", 64'(branch_inst), 64'd0);
    #10 rst_n = 1;
    step();

    drive(2'b11, add_i(3, 1, 2), add_i(6, 4, 5), 32'h0);
    step();
    idle();
    chk("add_count", 64'(count), 64'd2);
    chk("add_src1", 64'(dispatch_packet[0].src1), 64'd1);
    chk("add_src2", 64'(dispatch_packet[0].src2), 64'd2);
    chk("add_dest0", 64'(dispatch_packet[0].dest), 64'd3);
    chk("add_dest1", 64'(dispatch_packet[1].dest), 64'd6);
    chk("add_pc1", 64'(dispatch_packet[1].PC), 64'h4);
    chk("add_npc0", 64'(dispatch_packet[0].NPC), 64'h4);

    for (int p = 1; p < 4; p++) begin
      drive(2'b11, add_i(7, 1, 1), add_i(8, 2, 2), 32'(p * 8));
      step();
    end
    idle();
    chk("full_count", 64'(count), 64'd8);
    chk("full_ready", 64'(fetch_ready), 64'd0);
    drive(2'b11, add_i(9, 1, 1), add_i(9, 1, 1), 32'h100);
    step();
    idle();
    chk("full_hold", 64'(count), 64'd8);
    chk("full_oldest", 64'(dispatch_packet[0].PC), 64'h0);

    dispatched = 2'b11;
    step();
    step();
    idle();
    chk("drain4_count", 64'(count), 64'd4);
    chk("drain4_pc", 64'(dispatch_packet[0].PC), 64'h10);
    dispatched = 2'b01;
    step();
    idle();
    chk("d01_count", 64'(count), 64'd3);
    chk("d01_pc", 64'(dispatch_packet[0].PC), 64'h14);
    dispatched = 2'b10;
    step();
    idle();
    chk("d10_count", 64'(count), 64'd3);
    chk("d10_pc", 64'(dispatch_packet[0].PC), 64'h14);

    drive(2'b11, add_i(1, 1, 1), add_i(2, 2, 2), 32'h20);
    step();
    idle();
    chk("pre_flush", 64'(count), 64'd5);
    drive(2'b11, add_i(1, 1, 1), add_i(2, 2, 2), 32'h28);
    dispatched = 2'b11;
    take_branch = 1'b1;
    #1;
    chk("flush_cyc_valid", 64'({dispatch_packet[1].valid,
                                dispatch_packet[0].valid}), 64'd0);
    step();
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'({dispatch_packet[1].valid,
                            dispatch_packet[0].valid}), 64'd0);
    chk("flush_ready", 64'(fetch_ready), 64'd1);

    nxt_pc = 32'h0;
    exp_pc = 32'h0;
    drive(2'b11, add_i(1, 2, 3), add_i(4, 5, 6), nxt_pc);
    nxt_pc = nxt_pc + 32'd8;
    step();
    for (int c = 0; c < 10; c++) begin
      drive(2'b11, add_i(1, 2, 3), add_i(4, 5, 6), nxt_pc);
      nxt_pc = nxt_pc + 32'd8;
      dispatched = 2'b11;
      chk("steady_pc0", 64'(dispatch_packet[0].PC), 64'(exp_pc));
      chk("steady_pc1", 64'(dispatch_packet[1].PC), 64'(exp_pc + 32'd4));
      exp_pc = exp_pc + 32'd8;
      step();
      chk("steady_count", 64'(count), 64'd2);
    end
    idle();
    chk("steady_tail_pc", 64'(dispatch_packet[0].PC), 64'(exp_pc));

    dispatched = 2'b11;
    drive(2'b11, lw_i(10, 11), sw_i(12, 13), 32'h200);
    step();
    idle();
    chk("lw_src1", 64'(dispatch_packet[0].src1), 64'd11);
    chk("lw_src2", 64'(dispatch_packet[0].src2), 64'd0);
    chk("lw_dest", 64'(dispatch_packet[0].dest), 64'd10);
    chk("sw_srcs", 64'({dispatch_packet[1].src1,
                        dispatch_packet[1].src2}), 64'({5'd13, 5'd12}));
    chk("sw_dest", 64'(dispatch_packet[1].dest), 64'd0);
    chk("lwsw_branch", 64'(branch_inst), 64'd0);

    dispatched = 2'b11;
    drive(2'b11, add_i(7, 1, 2), beq_i(8, 9), 32'h300);
    step();
    idle();
    chk("beq_count", 64'(count), 64'd2);
    chk("beq_branch", 64'(branch_inst), 64'b10);
    chk("beq_dest", 64'(dispatch_packet[1].dest), 64'd0);
    chk("beq_srcs", 64'({dispatch_packet[1].src1,
                         dispatch_packet[1].src2}), 64'({5'd8, 5'd9}));

    drive(2'b11, add_i(1, 1, 1), add_i(2, 2, 2), 32'h308);
    step();
    idle();
    chk("mid_count", 64'(count), 64'd4);
    #2;
    rst_n = 0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_valid", 64'({dispatch_packet[1].valid,
                            dispatch_packet[0].valid}), 64'd0);
    chk("async_branch", 64'(branch_inst), 64'd0);
    chk("async_ready", 64'(fetch_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
